// File: rtl/tick_sched_pkg.sv
// Shared encodings for the run/pause/step tick scheduler.
package tick_sched_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_STEP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_STEP  = 2'd3
  } cmd_t;

endpackage

// File: rtl/tick_counter.sv
// Modulo-div counter producing a registered one-cycle tick on each wrap.
module tick_counter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned RST_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] div
);

  logic last_c;
  logic wrap_c;

  // div is never 0, so div-1 cannot underflow
  assign last_c = (cnt == div - CNT_W'(1));
  // clr while enabled forces an immediate wrap (single step)
  assign wrap_c = en && (clr || last_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      div  <= CNT_W'(RST_DIV);
    end else begin
      tick <= wrap_c;
      if (load) div <= div_in;
      if (load || clr || wrap_c) cnt <= '0;
      else if (en)               cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Run/pause/single-step controller driving the slow step tick and fast scan tick,
// with runtime divisor updates applied at the affected channel's wrap.
module tick_sched_ctrl
  import tick_sched_pkg::*;
#(
  parameter int unsigned SLOW_DIV = 400_000_000,
  parameter int unsigned FAST_DIV = 20_000,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk100MHz,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             slow_tick,
  output logic             fast_tick,
  output logic [1:0]       state
);

  state_t           state_q, state_n;
  cmd_t             cmd_c;
  logic             cmd_fire, cfg_fire;
  logic             pend_sel_q;
  logic [CNT_W-1:0] pend_div_q;
  logic             slow_en, slow_clr, slow_load, slow_last_c;
  logic             fast_en, fast_clr, fast_load, fast_last_c;
  logic [CNT_W-1:0] slow_cnt, slow_div, fast_cnt, fast_div;

  assign cmd_c    = cmd_t'(cmd);
  assign cmd_fire = cmd_valid && cmd_ready;
  assign cfg_fire = cfg_valid && cfg_ready;
  assign state    = state_q;

  assign slow_last_c = (slow_cnt == slow_div - CNT_W'(1));
  assign fast_last_c = (fast_cnt == fast_div - CNT_W'(1));

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_n;
      cmd_ready <= (state_n != ST_STEP);
    end
  end

  // Next state plus per-channel counter control; counters follow the new state
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && cmd_c == CMD_RUN)        state_n = ST_RUN;
        else if (cmd_fire && cmd_c == CMD_PAUSE) state_n = ST_PAUSED;
      end
      ST_RUN: begin
        if (cmd_fire && cmd_c == CMD_PAUSE) state_n = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (cmd_fire && cmd_c == CMD_RUN)       state_n = ST_RUN;
        else if (cmd_fire && cmd_c == CMD_STEP) state_n = ST_STEP;
      end
      ST_STEP: state_n = ST_PAUSED;
      default: state_n = ST_IDLE;
    endcase

    // A slow wrap on the same edge as PAUSE still completes
    slow_en  = (state_n == ST_RUN) || (state_n == ST_STEP) ||
               ((state_q == ST_RUN) && slow_last_c);
    slow_clr = (state_n == ST_IDLE) || (state_n == ST_STEP);
    fast_en  = (state_n != ST_IDLE);
    fast_clr = (state_n == ST_IDLE);

    slow_load = !cfg_ready && !pend_sel_q && (!slow_en || slow_clr || slow_last_c);
    fast_load = !cfg_ready &&  pend_sel_q && (!fast_en || fast_last_c);
  end

  // Shadow divisor; cfg_ready low doubles as the pending flag
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b1;
      pend_sel_q <= 1'b0;
      pend_div_q <= '0;
    end else if (cfg_fire) begin
      cfg_ready  <= 1'b0;
      pend_sel_q <= cfg_sel;
      pend_div_q <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    end else if (slow_load || fast_load) begin
      cfg_ready  <= 1'b1;
    end
  end

  tick_counter #(.CNT_W(CNT_W), .RST_DIV(SLOW_DIV)) u_slow (
    .clk    (clk100MHz),
    .rst_n  (rst_n),
    .en     (slow_en),
    .clr    (slow_clr),
    .load   (slow_load),
    .div_in (pend_div_q),
    .tick   (slow_tick),
    .cnt    (slow_cnt),
    .div    (slow_div)
  );

  tick_counter #(.CNT_W(CNT_W), .RST_DIV(FAST_DIV)) u_fast (
    .clk    (clk100MHz),
    .rst_n  (rst_n),
    .en     (fast_en),
    .clr    (fast_clr),
    .load   (fast_load),
    .div_in (pend_div_q),
    .tick   (fast_tick),
    .cnt    (fast_cnt),
    .div    (fast_div)
  );

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Vector-table bench for tick_sched_ctrl with a scoreboard of per-cycle expectations.
module tb_tick_sched_ctrl;
  import tick_sched_pkg::*;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [1:0] st;
    logic       ts;
    logic       tf;
    logic       cr;
    logic       gr;
  } exp_t;

  typedef struct packed {
    logic             cv;
    logic [1:0]       c;
    logic             gv;
    logic             gs;
    logic [CNT_W-1:0] gd;
    exp_t             e;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic             cfg_valid;
  logic             cfg_sel;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             slow_tick;
  logic             fast_tick;
  logic [1:0]       state;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tick_sched_ctrl #(.SLOW_DIV(4), .FAST_DIV(3), .CNT_W(CNT_W)) dut (
    .clk100MHz (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .slow_tick (slow_tick),
    .fast_tick (fast_tick),
    .state     (state)
  );

  function automatic exp_t mk(input int st, input bit ts, input bit tf, input bit cr, input bit gr);
    exp_t e;
    e.st = 2'(st);
    e.ts = ts;
    e.tf = tf;
    e.cr = cr;
    e.gr = gr;
    return e;
  endfunction

  function automatic void add(input bit cv, input logic [1:0] c, input bit gv, input bit gs,
                              input logic [CNT_W-1:0] gd, input exp_t e);
    vec_t v;
    v.cv = cv;
    v.c  = c;
    v.gv = gv;
    v.gs = gs;
    v.gd = gd;
    v.e  = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag);
    exp_t act;
    exp_t e;
    act = {state, slow_tick, fast_tick, cmd_ready, cfg_ready};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got st=%0d", tag, act.st);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d slow=%b fast=%b cmd_rdy=%b cfg_rdy=%b, want st=%0d slow=%b fast=%b cmd_rdy=%b cfg_rdy=%b",
               tag, act.st, act.ts, act.tf, act.cr, act.gr, e.st, e.ts, e.tf, e.cr, e.gr);
    end
  endtask

  // Drive each row for one cycle; its expectation covers outputs after that edge
  task automatic run_vecs(input string phase);
    for (int i = 0; i < vecs.size(); i++) begin
      cmd_valid = vecs[i].cv;
      cmd       = vecs[i].c;
      cfg_valid = vecs[i].gv;
      cfg_sel   = vecs[i].gs;
      cfg_div   = vecs[i].gd;
      exp_q.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", phase, i + 1));
    end
    cmd_valid = 1'b0;
    cfg_valid = 1'b0;
    vecs.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_div   = '0;

    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) add(0, CMD_NOP, 0, 0, '0, mk(0, 0, 0, 1, 1));
    run_vecs("idle");

    // Edge k after the RUN command; fast phase runs uninterrupted from k=1
    for (int k = 1; k <= 57; k++) begin
      bit cv, gv, gs, ts, tf, cr, gr;
      logic [1:0] c;
      logic [CNT_W-1:0] gd;
      int st;
      cv = 0; c = CMD_NOP; gv = 0; gs = 0; gd = '0;
      case (k)
        1, 26, 34, 36: begin cv = 1; c = CMD_RUN;   end
        15, 31:        begin cv = 1; c = CMD_PAUSE; end
        33:            begin cv = 1; c = CMD_STEP;  end
        default: ;
      endcase
      case (k)
        40: begin gv = 1; gs = 0; gd = CNT_W'(6); end
        50: begin gv = 1; gs = 1; gd = CNT_W'(0); end
        57: begin gv = 1; gs = 0; gd = CNT_W'(5); end
        default: ;
      endcase
      if (k <= 14)      st = 1;
      else if (k <= 25) st = 2;
      else if (k <= 30) st = 1;
      else if (k <= 32) st = 2;
      else if (k == 33) st = 3;
      else if (k <= 35) st = 2;
      else              st = 1;
      if (k <= 14)      ts = (k % 4 == 0);
      else if (k <= 26) ts = 0;
      else if (k <= 30) ts = (k == 27);
      else if (k == 31) ts = 1;
      else if (k == 32) ts = 0;
      else if (k == 33) ts = 1;
      else if (k <= 38) ts = 0;
      else if (k <= 43) ts = (k == 39 || k == 43);
      else              ts = ((k - 43) % 6 == 0);
      tf = (k <= 51) ? (k % 3 == 0) : 1'b1;
      cr = (k != 33);
      gr = !((k >= 40 && k <= 42) || k == 50 || k == 57);
      add(cv, c, gv, gs, gd, mk(st, ts, tf, cr, gr));
    end
    run_vecs("main");

    // Asynchronous reset mid-cycle with a slow update still pending
    #2;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    check("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int m = 1; m <= 13; m++)
      add(m == 1, (m == 1) ? CMD_RUN : CMD_NOP, 0, 0, '0,
          mk(1, (m % 4 == 0), (m % 3 == 0), 1, 1));
    run_vecs("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
